// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for the CLB array.
// Decodes a framed, parity-protected bitstream (preamble 0010, frame count,
// then start/payload/parity/stop per CLB) into one parallel write per CLB.
module clb_cfg_loader #(
    parameter int CFG_W   = 37,
    parameter int LEN_W   = 8,
    parameter int NUM_CLB = 64,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_en,
    output logic [CFG_W-1:0]  cfg_data,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic              cfg_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int MAX_F = (CFG_W > LEN_W) ? CFG_W : LEN_W;
    localparam int CNT_W = $clog2(MAX_F + 1);
    localparam logic [LEN_W:0] MAX_N = (LEN_W + 1)'(NUM_CLB);

    // S_FIN covers the write-strobe cycle of the final frame so that done
    // rises together with the last address increment.
    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_LEN,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_FIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   bit_cnt;
    logic [LEN_W-2:0]   len_sr;
    logic [LEN_W-1:0]   len_val;
    logic [LEN_W-1:0]   rem_cnt;
    logic [CFG_W-1:0]   shift_sr;

    logic               wr_issue;
    logic               err_set;
    logic [1:0]         err_code_n;
    logic               addr_clr;
    logic               len_load;

    // Frame count including the bit arriving on this edge (MSB first).
    assign len_val = {len_sr, din};

    assign busy = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; every decision is taken only on a qualified bit,
    // except leaving S_FIN, which is the final write's bookkeeping edge.
    always_comb begin
        state_n    = state;
        wr_issue   = 1'b0;
        err_set    = 1'b0;
        err_code_n = 2'b00;
        addr_clr   = 1'b0;
        len_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (din_en && !din) begin
                    state_n = S_PRE;
                end
            end
            S_PRE: begin
                // bit_cnt = preamble bits already accepted; only the third is 1.
                if (din_en) begin
                    if (din != (bit_cnt == CNT_W'(2))) begin
                        state_n = S_IDLE;
                    end else if (bit_cnt == CNT_W'(3)) begin
                        state_n = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (din_en && (bit_cnt == CNT_W'(LEN_W - 1))) begin
                    len_load = 1'b1;
                    if (len_val == '0) begin
                        state_n = S_DONE;
                    end else if ({1'b0, len_val} > MAX_N) begin
                        err_set    = 1'b1;
                        err_code_n = 2'b11;
                        state_n    = S_ERR;
                    end else begin
                        addr_clr = 1'b1;
                        state_n  = S_START;
                    end
                end
            end
            S_START: begin
                if (din_en) begin
                    if (din) begin
                        err_set    = 1'b1;
                        err_code_n = 2'b01;
                        state_n    = S_ERR;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (din_en && (bit_cnt == CNT_W'(CFG_W - 1))) begin
                    state_n = S_PAR;
                end
            end
            S_PAR: begin
                // Even parity over payload plus parity bit.
                if (din_en) begin
                    if ((^shift_sr) ^ din) begin
                        err_set    = 1'b1;
                        err_code_n = 2'b10;
                        state_n    = S_ERR;
                    end else begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (din_en) begin
                    if (!din) begin
                        err_set    = 1'b1;
                        err_code_n = 2'b01;
                        state_n    = S_ERR;
                    end else begin
                        wr_issue = 1'b1;
                        state_n  = (rem_cnt == LEN_W'(1)) ? S_FIN : S_START;
                    end
                end
            end
            S_FIN: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    // Field bit counter and the header / payload shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            len_sr   <= '0;
            shift_sr <= '0;
        end else begin
            if (state_n != state) begin
                // The bit that leaves IDLE is already the first preamble bit.
                bit_cnt <= (state_n == S_PRE) ? CNT_W'(1) : '0;
            end else if (din_en && ((state == S_PRE) || (state == S_LEN) || (state == S_DATA))) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (din_en && (state == S_LEN)) begin
                len_sr <= len_val[LEN_W-2:0];
            end
            if (din_en && (state == S_DATA)) begin
                shift_sr <= {shift_sr[CFG_W-2:0], din};
            end
        end
    end

    // Write port, frame bookkeeping and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_we   <= 1'b0;
            cfg_data <= '0;
            cfg_addr <= '0;
            rem_cnt  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            cfg_we <= wr_issue;
            if (wr_issue) begin
                cfg_data <= shift_sr;
            end
            // Address and remaining count advance on the edge that ends the strobe.
            if (addr_clr) begin
                cfg_addr <= '0;
            end else if (cfg_we) begin
                cfg_addr <= cfg_addr + ADDR_W'(1);
            end
            if (len_load) begin
                rem_cnt <= len_val;
            end else if (cfg_we) begin
                rem_cnt <= rem_cnt - LEN_W'(1);
            end
            if (state_n == S_DONE) begin
                done <= 1'b1;
            end
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_code_n;
            end
        end
    end

endmodule
